msg_stage_reg: RTL and testbench
================================

// Module: msg_stage_reg
// PURPOSE
//  Pipeline stage register that builds and holds the packed per-instruction message bus (`MAX bits, field slices from macro.v).
//  Takes the message from the previous stage and lets the current stage overwrite selected fields (AO, WD, tarReg, grfWE, branch, md, busy).
//  Decrements tnew as the instruction advances and supports stall (hold) and flush (bubble insert).
//  Sits between every pair of stages: D/E, E/M and M/W. Downstream logic unpacks the registered bus.
// PARAMETERS
//  TNEW_DEC  1  amount subtracted from tnew per stage; the result saturates at 0.
//  BUB_PC    0  when 1, a bubble keeps the incoming pc field so exception and trace logic can still use it; when 0, pc is cleared.
// PORTS
//  clk        in   1      rising-edge clock; the only clock.
//  reset      in   1      synchronous, active-high; clears msg_out to the bubble value.
//  stall      in   1      hold msg_out unchanged this cycle.
//  flush      in   1      load the bubble value this cycle.
//  msg_in     in   `MAX   packed message from the previous stage.
//  ao_we      in   1      replace the AO field with ao_in.
//  ao_in      in   32     ALU/address result.
//  wd_we      in   1      replace the WD field with wd_in.
//  wd_in      in   32     write-back data.
//  dst_we     in   1      replace tarReg and grfWE with tar_in and gwe_in.
//  tar_in     in   5      destination register.
//  gwe_in     in   1      GRF write enable.
//  br_we      in   1      replace the branch field with br_in.
//  br_in      in   1      branch taken.
//  md_in      in   1      OR-ed into the md field.
//  busy_in    in   1      replaces the busy field on every load.
//  msg_out    out  `MAX   registered packed message.
//  bubble     out  1      1 when msg_out holds a bubble (registered).
// BEHAVIOUR
//  Priority on each rising clk edge: reset > flush > stall > load.
//  - reset: msg_out = BUBBLE, bubble = 1.
//  - flush: msg_out = BUBBLE, bubble = 1. If BUB_PC=1, the pc field = msg_in[`pc].
//  - stall (no flush): msg_out and bubble hold.
//  - load: msg_out = merge(msg_in), bubble = 0.
//  - BUBBLE: all fields 0 (instr = nop 0x0000_0000, tarReg = 0, grfWE = 0, tnew = 0, rsuse = rtuse = 4'hF).
//    rsuse/rtuse = F means "no use", so a bubble never causes a stall.
//  Merge rules (combinational, then registered):
//  - Each field with its *_we high takes the new value; otherwise it passes through from msg_in.
//  - instr, pc, RS, RT, npc, ext32, rsuse, rtuse always pass through.
//  - tnew_out = (tnew_in > TNEW_DEC) ? tnew_in - TNEW_DEC : 0, as 4-bit unsigned. There is no wrap-around: 0 stays 0.
//  - If dst_we is high and tar_in = 0, grfWE_out is forced to 0. $0 is never written.
//  - md_out = msg_in[`md] | md_in. busy_out = busy_in.
//  Latency is one cycle, input to msg_out. No combinational path from any input to msg_out.
//  Stall while already holding a bubble: the register stays a bubble.
//  Flush asserted in the reset cycle: the bubble value results; the two are indistinguishable.
//  Reset mid-operation discards the held instruction. The first load after reset is accepted in the same cycle reset deasserts.
// STRUCTURE
//  - Field slice macros (`instr, `pc, `RS, `RT, `npc, `ext32, `AO, `WD, `tarReg, `rtuse, `rsuse, `tnew, `grfWE, `branch, `md, `busy), `MAX and a new `BUBBLE_MSG constant all live in macro.v.
//  - One sub-module: msg_merge, purely combinational. Inputs: msg_in, the override ports and TNEW_DEC. Output: the merged `MAX bus.
//  - msg_stage_reg contains msg_merge, the priority mux and the register.
// TESTING
//  1 Reset: reset=1 for 2 cycles with random msg_in -> msg_out = BUBBLE_MSG, bubble = 1, rsuse = F.
//  2 Load/tnew: msg_in tnew=2, ao_we=1, ao_in=0x1234_5678 -> next cycle tnew=1 and AO=0x1234_5678, other fields equal msg_in.
//    Repeat with tnew=0 -> tnew stays 0.
//  3 Stall: load pc=0x3000, then stall=1 for 3 cycles while msg_in changes -> msg_out constant, pc=0x3000.
//  4 Flush vs stall: stall=1 and flush=1 together, BUB_PC=1, msg_in pc=0x3004 -> bubble=1, pc=0x3004, grfWE=0.
//  5 $0 guard: dst_we=1, tar_in=0, gwe_in=1 -> grfWE=0. With tar_in=5 -> tarReg=5, grfWE=1.
//  6 md/busy: msg_in md=1, md_in=0, busy_in=1 -> md=1, busy=1. Next cycle busy_in=0 -> busy=0.

Source files
------------

// File: rtl/msg_stage_reg_pkg.sv
// Shared layout of the per-instruction pipeline message and its bubble value.
package msg_stage_reg_pkg;

   // Field order is MSB first; instr occupies the low 32 bits.
   typedef struct packed {
      logic        busy;
      logic        md;
      logic        branch;
      logic        grf_we;
      logic [3:0]  tnew;
      logic [3:0]  rsuse;
      logic [3:0]  rtuse;
      logic [4:0]  tar_reg;
      logic [31:0] wd;
      logic [31:0] ao;
      logic [31:0] ext32;
      logic [31:0] npc;
      logic [4:0]  rt;
      logic [4:0]  rs;
      logic [31:0] pc;
      logic [31:0] instr;
   } msg_t;

   localparam int unsigned MsgW = $bits(msg_t);

   // rsuse/rtuse = F marks "no operand use", so a bubble never triggers a hazard stall.
   function automatic msg_t bubble_msg();
      msg_t m;
      m       = '0;
      m.rsuse = 4'hF;
      m.rtuse = 4'hF;
      return m;
   endfunction

endpackage

// File: rtl/msg_merge.sv
// Combinational merge of the incoming message with this stage's field overrides.
module msg_merge
   import msg_stage_reg_pkg::*;
#(
   parameter int unsigned TNEW_DEC = 1
) (
   input  logic [MsgW-1:0] msg_in,
   input  logic            ao_we,
   input  logic [31:0]     ao_in,
   input  logic            wd_we,
   input  logic [31:0]     wd_in,
   input  logic            dst_we,
   input  logic [4:0]      tar_in,
   input  logic            gwe_in,
   input  logic            br_we,
   input  logic            br_in,
   input  logic            md_in,
   input  logic            busy_in,
   output logic [MsgW-1:0] merged
);

   msg_t src;
   msg_t m;

   assign src = msg_t'(msg_in);

   always_comb begin
      m = src;
      if (ao_we) m.ao = ao_in;
      if (wd_we) m.wd = wd_in;
      if (dst_we) begin
         m.tar_reg = tar_in;
         m.grf_we  = gwe_in & (tar_in != 5'd0);
      end
      if (br_we) m.branch = br_in;
      // Saturating decrement: an instruction that is already ready stays ready.
      if (32'(src.tnew) > TNEW_DEC) begin
         m.tnew = 4'(32'(src.tnew) - TNEW_DEC);
      end else begin
         m.tnew = 4'd0;
      end
      m.md   = src.md | md_in;
      m.busy = busy_in;
   end

   assign merged = m;

endmodule

// File: rtl/msg_stage_reg.sv
// Pipeline stage register for the packed message bus with stall and flush handling.
module msg_stage_reg
   import msg_stage_reg_pkg::*;
#(
   parameter int unsigned TNEW_DEC = 1,
   parameter bit          BUB_PC   = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic [MsgW-1:0] msg_in,
   input  logic            ao_we,
   input  logic [31:0]     ao_in,
   input  logic            wd_we,
   input  logic [31:0]     wd_in,
   input  logic            dst_we,
   input  logic [4:0]      tar_in,
   input  logic            gwe_in,
   input  logic            br_we,
   input  logic            br_in,
   input  logic            md_in,
   input  logic            busy_in,
   output logic [MsgW-1:0] msg_out,
   output logic            bubble
);

   logic [MsgW-1:0] merged;
   msg_t            src;
   msg_t            bub_val;
   msg_t            msg_d, msg_q;
   logic            bubble_d, bubble_q;

   msg_merge #(
      .TNEW_DEC(TNEW_DEC)
   ) u_merge (
      .msg_in (msg_in),
      .ao_we  (ao_we),
      .ao_in  (ao_in),
      .wd_we  (wd_we),
      .wd_in  (wd_in),
      .dst_we (dst_we),
      .tar_in (tar_in),
      .gwe_in (gwe_in),
      .br_we  (br_we),
      .br_in  (br_in),
      .md_in  (md_in),
      .busy_in(busy_in),
      .merged (merged)
   );

   assign src = msg_t'(msg_in);

   always_comb begin
      bub_val = bubble_msg();
      // Keeping pc in a flushed slot lets exception and trace logic still see it.
      if (BUB_PC) bub_val.pc = src.pc;
      msg_d    = msg_q;
      bubble_d = bubble_q;
      if (flush) begin
         msg_d    = bub_val;
         bubble_d = 1'b1;
      end else if (!stall) begin
         msg_d    = msg_t'(merged);
         bubble_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         msg_q    <= bubble_msg();
         bubble_q <= 1'b1;
      end else begin
         msg_q    <= msg_d;
         bubble_q <= bubble_d;
      end
   end

   assign msg_out = msg_q;
   assign bubble  = bubble_q;

endmodule

// File: tb/tb_msg_stage_reg.sv
// Randomized scoreboard bench for msg_stage_reg against a field-level reference model.
module tb_msg_stage_reg;
   import msg_stage_reg_pkg::*;

   localparam int TDec = 1;

   typedef struct {
      msg_t m;
      logic b;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   msg_t        msg_in_s;
   logic        ao_we, wd_we, dst_we, gwe_in, br_we, br_in, md_in, busy_in;
   logic [31:0] ao_in, wd_in;
   logic [4:0]  tar_in;
   logic [MsgW-1:0] msg_out;
   logic        bubble;

   exp_t sbq[$];
   exp_t mon_e;
   msg_t model_msg;
   logic model_bub;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   msg_stage_reg #(
      .TNEW_DEC(TDec),
      .BUB_PC  (1'b1)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .stall  (stall),
      .flush  (flush),
      .msg_in (msg_in_s),
      .ao_we  (ao_we),
      .ao_in  (ao_in),
      .wd_we  (wd_we),
      .wd_in  (wd_in),
      .dst_we (dst_we),
      .tar_in (tar_in),
      .gwe_in (gwe_in),
      .br_we  (br_we),
      .br_in  (br_in),
      .md_in  (md_in),
      .busy_in(busy_in),
      .msg_out(msg_out),
      .bubble (bubble)
   );

   // Monitor: every registered output is checked against the oldest pending expectation.
   always @(posedge clk) begin
      #1;
      if (sbq.size() != 0) begin
         mon_e = sbq.pop_front();
         n_vec++;
         if (msg_out !== mon_e.m || bubble !== mon_e.b) begin
            n_bad++;
            $display("FAIL msg_out vec %0d: got %h bub=%b, expected %h bub=%b",
                     n_vec, msg_out, bubble, mon_e.m, mon_e.b);
         end
      end
   end

   function automatic msg_t rand_msg();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return msg_t'(r[MsgW-1:0]);
   endfunction

   function automatic msg_t ref_bubble();
      msg_t m = '0;
      m.rsuse = 4'hF;
      m.rtuse = 4'hF;
      return m;
   endfunction

   // Reference: apply the stage rules field by field, then issue one clock.
   task automatic step();
      exp_t e;
      msg_t m;
      int   t;
      if (reset) begin
         model_msg = ref_bubble();
         model_bub = 1'b1;
      end else if (flush) begin
         model_msg    = ref_bubble();
         model_msg.pc = msg_in_s.pc;
         model_bub    = 1'b1;
      end else if (!stall) begin
         m = msg_in_s;
         if (ao_we) m.ao = ao_in;
         if (wd_we) m.wd = wd_in;
         if (dst_we) begin
            m.tar_reg = tar_in;
            m.grf_we  = (tar_in == 5'd0) ? 1'b0 : gwe_in;
         end
         if (br_we) m.branch = br_in;
         t = int'(msg_in_s.tnew) - TDec;
         m.tnew = (t > 0) ? 4'(t) : 4'd0;
         m.md   = msg_in_s.md | md_in;
         m.busy = busy_in;
         model_msg = m;
         model_bub = 1'b0;
      end
      e.m = model_msg;
      e.b = model_bub;
      sbq.push_back(e);
      @(negedge clk);
   endtask

   task automatic quiet();
      reset = 0; stall = 0; flush = 0;
      ao_we = 0; wd_we = 0; dst_we = 0; br_we = 0;
      ao_in = 0; wd_in = 0; tar_in = 0; gwe_in = 0; br_in = 0; md_in = 0; busy_in = 0;
   endtask

   initial begin
      quiet();
      // Reset with random traffic on msg_in
      reset = 1;
      msg_in_s = rand_msg(); step();
      msg_in_s = rand_msg(); step();
      reset = 0;

      // Load with tnew decrement and AO override, then tnew already 0
      msg_in_s = rand_msg(); msg_in_s.tnew = 4'd2;
      ao_we = 1; ao_in = 32'h1234_5678; busy_in = msg_in_s.busy; step();
      msg_in_s = rand_msg(); msg_in_s.tnew = 4'd0; busy_in = msg_in_s.busy; step();
      msg_in_s.tnew = 4'd1; step();
      msg_in_s.tnew = 4'hF; step();
      quiet();

      // Stall holds a loaded pc while msg_in keeps changing
      msg_in_s = rand_msg(); msg_in_s.pc = 32'h0000_3000; step();
      stall = 1;
      for (int i = 0; i < 3; i++) begin msg_in_s = rand_msg(); step(); end

      // Flush beats stall; pc kept
      flush = 1; msg_in_s = rand_msg(); msg_in_s.pc = 32'h0000_3004; step();
      flush = 0; msg_in_s = rand_msg(); step();
      stall = 0;

      // $0 write guard
      dst_we = 1; tar_in = 5'd0; gwe_in = 1; msg_in_s = rand_msg(); step();
      tar_in = 5'd5; step();
      quiet();

      // md accumulation and busy replacement
      msg_in_s = rand_msg(); msg_in_s.md = 1; busy_in = 1; step();
      busy_in = 0; step();
      msg_in_s.md = 0; md_in = 1; step();
      quiet();

      // Flush during reset, then load in the cycle reset drops
      reset = 1; flush = 1; msg_in_s = rand_msg(); step();
      reset = 0; flush = 0; msg_in_s = rand_msg(); step();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         msg_in_s = rand_msg();
         reset   = ($urandom_range(0, 29) == 0);
         flush   = ($urandom_range(0, 7) == 0);
         stall   = ($urandom_range(0, 3) == 0);
         ao_we   = $urandom_range(0, 1) == 1;
         wd_we   = $urandom_range(0, 1) == 1;
         dst_we  = $urandom_range(0, 1) == 1;
         br_we   = $urandom_range(0, 1) == 1;
         ao_in   = $urandom;
         wd_in   = $urandom;
         tar_in  = 5'($urandom_range(0, 7));
         gwe_in  = $urandom_range(0, 1) == 1;
         br_in   = $urandom_range(0, 1) == 1;
         md_in   = $urandom_range(0, 1) == 1;
         busy_in = $urandom_range(0, 1) == 1;
         step();
      end
      quiet();
      msg_in_s = rand_msg(); step();

      for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
      if (sbq.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
